// File: rtl/mult_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : mult_arbiter_if
//  Brief    : Requester, multiplier and response signals of mult_arbiter
//  Revision : 1.0
// ============================================================================
interface mult_arbiter_if #(
    parameter int WIDTH = 32
);
    logic [1:0]            iReqVld;
    logic [1:0]            oReqRdy;
    logic [1:0][WIDTH-1:0] iReqS1;
    logic [1:0][WIDTH-1:0] iReqS2;
    logic [1:0]            iReqS1Sign;
    logic [1:0]            iReqS2Sign;
    logic [1:0]            iReqHigh;
    logic [WIDTH-1:0]      oMulS1;
    logic [WIDTH-1:0]      oMulS2;
    logic                  oMulS1Sign;
    logic                  oMulS2Sign;
    logic [1:0]            oMulOpEn;
    logic                  oMulVld;
    logic [WIDTH-1:0]      iMulResult;
    logic [1:0]            oRspVld;
    logic [1:0]            iRspRdy;
    logic [1:0][WIDTH-1:0] oRspData;
    logic                  oBusy;

    modport slave (
        input  iReqVld, iReqS1, iReqS2, iReqS1Sign, iReqS2Sign, iReqHigh,
        input  iMulResult, iRspRdy,
        output oReqRdy, oMulS1, oMulS2, oMulS1Sign, oMulS2Sign, oMulOpEn,
        output oMulVld, oRspVld, oRspData, oBusy
    );

    modport master (
        output iReqVld, iReqS1, iReqS2, iReqS1Sign, iReqS2Sign, iReqHigh,
        output iMulResult, iRspRdy,
        input  oReqRdy, oMulS1, oMulS2, oMulS1Sign, oMulS2Sign, oMulOpEn,
        input  oMulVld, oRspVld, oRspData, oBusy
    );
endinterface
`default_nettype wire

// File: rtl/mult_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mult_arbiter
//  Brief    : Round-robin, credit-limited sharing of one pipelined multiplier
//             between two requesters with per-requester in-order result FIFOs
//  Revision : 1.0
// ============================================================================
module mult_arbiter #(
    parameter int WIDTH = 32,
    parameter int LAT   = 3
) (
    input  logic          clk,
    input  logic          rst,
    mult_arbiter_if.slave bus
);
    logic                       ptr_q, ptr_d;
    logic [1:0][1:0]            cnt_q, cnt_d;
    logic [LAT-1:0]             tag_vld_q;
    logic [LAT-1:0]             tag_id_q;
    logic [1:0][1:0][WIDTH-1:0] fifo_mem_q;
    logic [1:0]                 fifo_wp_q;
    logic [1:0]                 fifo_rp_q;
    logic [1:0][1:0]            fifo_cnt_q;

    logic [1:0] w_elig, w_grant, w_push, w_pop, w_nonempty, w_rsp_vld;
    logic       w_gid, w_mul_vld;

    // Credit counts cover both in-flight and buffered results, so a grant can
    // never overflow the 2-entry FIFO even without backpressure on the pipe.
    always_comb begin
        w_elig  = 2'b00;
        w_grant = 2'b00;
        w_gid   = 1'b0;
        for (int r = 0; r < 2; r++) begin
            w_elig[r] = bus.iReqVld[r] && (cnt_q[r] != 2'd2) && !rst;
        end
        if (w_elig[ptr_q]) begin
            w_grant[ptr_q] = 1'b1;
            w_gid          = ptr_q;
        end else if (w_elig[~ptr_q]) begin
            w_grant[~ptr_q] = 1'b1;
            w_gid           = ~ptr_q;
        end
    end

    assign w_mul_vld      = |w_grant;
    assign ptr_d          = w_mul_vld ? ~w_gid : ptr_q;
    assign bus.oReqRdy    = w_grant;
    assign bus.oMulVld    = w_mul_vld;
    assign bus.oMulS1     = w_mul_vld ? bus.iReqS1[w_gid] : '0;
    assign bus.oMulS2     = w_mul_vld ? bus.iReqS2[w_gid] : '0;
    assign bus.oMulS1Sign = w_mul_vld && bus.iReqS1Sign[w_gid];
    assign bus.oMulS2Sign = w_mul_vld && bus.iReqS2Sign[w_gid];
    assign bus.oMulOpEn   = !w_mul_vld ? 2'b00 : (bus.iReqHigh[w_gid] ? 2'b01 : 2'b10);

    always_comb begin
        w_push     = 2'b00;
        w_pop      = 2'b00;
        w_nonempty = 2'b00;
        w_rsp_vld  = 2'b00;
        cnt_d      = cnt_q;
        for (int r = 0; r < 2; r++) begin
            w_nonempty[r] = (fifo_cnt_q[r] != 2'd0);
            w_rsp_vld[r]  = w_nonempty[r] && !rst;
            w_pop[r]      = w_rsp_vld[r] && bus.iRspRdy[r];
            w_push[r]     = tag_vld_q[LAT-1] && (tag_id_q[LAT-1] == 1'(r));
            case ({w_grant[r], w_pop[r]})
                2'b10:   cnt_d[r] = cnt_q[r] + 2'd1;
                2'b01:   cnt_d[r] = cnt_q[r] - 2'd1;
                default: cnt_d[r] = cnt_q[r];
            endcase
        end
    end

    assign bus.oRspVld = w_rsp_vld;
    assign bus.oBusy   = !rst && ((|tag_vld_q) || (|w_nonempty));

    for (genvar gr = 0; gr < 2; gr++) begin : g_rsp
        assign bus.oRspData[gr] = w_nonempty[gr] ? fifo_mem_q[gr][fifo_rp_q[gr]] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q      <= 1'b0;
            cnt_q      <= '0;
            tag_vld_q  <= '0;
            tag_id_q   <= '0;
            fifo_wp_q  <= '0;
            fifo_rp_q  <= '0;
            fifo_cnt_q <= '0;
        end else begin
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            tag_vld_q[0] <= w_mul_vld;
            tag_id_q[0]  <= w_gid;
            for (int i = 1; i < LAT; i++) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
                tag_id_q[i]  <= tag_id_q[i-1];
            end
            for (int r = 0; r < 2; r++) begin
                if (w_push[r]) fifo_wp_q[r] <= ~fifo_wp_q[r];
                if (w_pop[r])  fifo_rp_q[r] <= ~fifo_rp_q[r];
                case ({w_push[r], w_pop[r]})
                    2'b10:   fifo_cnt_q[r] <= fifo_cnt_q[r] + 2'd1;
                    2'b01:   fifo_cnt_q[r] <= fifo_cnt_q[r] - 2'd1;
                    default: fifo_cnt_q[r] <= fifo_cnt_q[r];
                endcase
            end
        end
    end

    // Storage needs no reset: occupancy is governed by fifo_cnt_q alone.
    always_ff @(posedge clk) begin
        for (int r = 0; r < 2; r++) begin
            if (w_push[r] && !rst) fifo_mem_q[r][fifo_wp_q[r]] <= bus.iMulResult;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_mult_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mult_arbiter
//  Brief    : Random and directed stimulus against a queue-based reference
//  Revision : 1.0
// ============================================================================
module tb_mult_arbiter;
    localparam int W   = 32;
    localparam int LAT = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mult_arbiter_if #(.WIDTH(W)) bus();

    mult_arbiter #(.WIDTH(W), .LAT(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [W-1:0] mul_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic sa, input logic sb, input logic hi);
        logic [2*W-1:0] ea, eb, p;
        ea = sa ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
        eb = sb ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
        p  = ea * eb;
        return hi ? p[2*W-1:W] : p[W-1:0];
    endfunction

    // External multiplier: result presented exactly LAT cycles after issue.
    logic [W-1:0] sched_d [8];
    int           sched_c [8] = '{default: -1};

    always @(posedge clk) begin
        #1;
        if (sched_c[cyc % 8] == cyc) bus.iMulResult = sched_d[cyc % 8];
        else                         bus.iMulResult = $urandom;
    end

    // Reference: each requester owns a queue of results tagged with the cycle
    // they become visible; queue length is the credit in use.
    typedef struct { logic [W-1:0] data; int rdy; } ent_t;
    ent_t mq [2][$];
    logic pr = 1'b0;

    always @(negedge clk) begin
        logic [1:0]   ev, eg;
        logic [W-1:0] ed;
        int           g;
        if (rst) begin
            chk("rst_oReqRdy", bus.oReqRdy, 0);
            chk("rst_oMulVld", bus.oMulVld, 0);
            chk("rst_oRspVld", bus.oRspVld, 0);
            chk("rst_oBusy",   bus.oBusy,   0);
            mq[0].delete();
            mq[1].delete();
            pr = 1'b0;
        end else begin
            g = -1;
            if (bus.iReqVld[pr] && mq[pr].size() < 2)            g = int'(pr);
            else if (bus.iReqVld[!pr] && mq[!pr].size() < 2)     g = int'(!pr);
            eg = (g < 0) ? 2'b00 : (2'b01 << g);
            chk("oReqRdy", bus.oReqRdy, eg);
            chk("oMulVld", bus.oMulVld, g >= 0);
            if (g < 0) begin
                chk("oMulOpEn_idle", bus.oMulOpEn, 2'b00);
                chk("oMul_operands_idle",
                    {bus.oMulS1Sign, bus.oMulS2Sign, bus.oMulS1, bus.oMulS2}, 0);
            end else begin
                chk("oMulOpEn", bus.oMulOpEn, bus.iReqHigh[g] ? 2'b01 : 2'b10);
                chk("oMul_operands",
                    {bus.oMulS1Sign, bus.oMulS2Sign, bus.oMulS1, bus.oMulS2},
                    {bus.iReqS1Sign[g], bus.iReqS2Sign[g], bus.iReqS1[g], bus.iReqS2[g]});
            end
            for (int r = 0; r < 2; r++) begin
                ev[r] = (mq[r].size() > 0) && (mq[r][0].rdy <= cyc);
                ed    = ev[r] ? mq[r][0].data : '0;
                chk("oRspVld", bus.oRspVld[r], ev[r]);
                chk("oRspData", bus.oRspData[r], ed);
            end
            chk("oBusy", bus.oBusy, (mq[0].size() + mq[1].size()) > 0);
            for (int r = 0; r < 2; r++) begin
                if (ev[r] && bus.iRspRdy[r]) void'(mq[r].pop_front());
            end
            if (g >= 0) begin
                mq[g].push_back('{mul_ref(bus.iReqS1[g], bus.iReqS2[g], bus.iReqS1Sign[g],
                                          bus.iReqS2Sign[g], bus.iReqHigh[g]),
                                  cyc + LAT + 1});
                pr = (g == 0);
            end
        end
        if (bus.oMulVld === 1'b1) begin
            sched_d[(cyc + LAT) % 8] = mul_ref(bus.oMulS1, bus.oMulS2, bus.oMulS1Sign,
                                               bus.oMulS2Sign, bus.oMulOpEn == 2'b01);
            sched_c[(cyc + LAT) % 8] = cyc + LAT;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic sa, input logic sb, input logic hi);
        bus.iReqS1[r]     = a;
        bus.iReqS2[r]     = b;
        bus.iReqS1Sign[r] = sa;
        bus.iReqS2Sign[r] = sb;
        bus.iReqHigh[r]   = hi;
    endtask

    function automatic logic [W-1:0] rnd_op();
        case ($urandom % 5)
            0:       return W'($urandom % 16);
            1:       return '1;
            2:       return {1'b1, {(W-1){1'b0}}};
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        int acc0, acc1;
        bus.iReqVld = 2'b00;
        bus.iRspRdy = 2'b11;
        set_req(0, '0, '0, 1'b0, 1'b0, 1'b0);
        set_req(1, '0, '0, 1'b0, 1'b0, 1'b0);
        repeat (3) step();
        rst = 1'b0;

        // Round-robin with both requesters always asking
        set_req(0, 32'd3, 32'd5, 1'b0, 1'b0, 1'b0);
        set_req(1, 32'd9, 32'd2, 1'b0, 1'b0, 1'b0);
        bus.iReqVld = 2'b11;
        for (int k = 0; k < 4; k++) begin
            mid();
            chk("rr_grant", bus.oReqRdy, (k % 2 == 0) ? 2'b01 : 2'b10);
            step();
        end
        bus.iReqVld = 2'b00;
        repeat (8) step();

        // 7 x 6 low half, result appears LAT+1 cycles after issue
        set_req(0, 32'd7, 32'd6, 1'b0, 1'b0, 1'b0);
        bus.iReqVld = 2'b01;
        mid();
        chk("basic_mulvld", bus.oMulVld, 1'b1);
        chk("basic_opEn",   bus.oMulOpEn, 2'b10);
        step();
        bus.iReqVld = 2'b00;
        step(); step();
        mid();
        chk("basic_rsp_early", bus.oRspVld[0], 1'b0);
        step();
        mid();
        chk("basic_rspvld", bus.oRspVld[0], 1'b1);
        chk("basic_rspdata", bus.oRspData[0], 32'd42);
        repeat (6) step();

        // High half of all-ones squared
        set_req(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);
        bus.iReqVld = 2'b01;
        mid();
        chk("high_opEn", bus.oMulOpEn, 2'b01);
        step();
        bus.iReqVld = 2'b00;
        repeat (3) step();
        mid();
        chk("high_rspdata", bus.oRspData[0], 32'hFFFF_FFFE);
        repeat (6) step();
        set_req(0, 32'd11, 32'd13, 1'b0, 1'b0, 1'b0);

        // Credit exhaustion on r0 while its consumer stalls
        bus.iRspRdy = 2'b10;
        bus.iReqVld = 2'b11;
        acc0 = 0;
        acc1 = 0;
        for (int k = 0; k < 4; k++) begin
            mid();
            acc0 += int'(bus.oReqRdy[0]);
            acc1 += int'(bus.oReqRdy[1]);
            step();
        end
        chk("credit_acc0", acc0, 2);
        chk("credit_acc1", acc1, 2);
        bus.iReqVld = 2'b01;
        for (int k = 0; k < 6; k++) begin
            mid();
            chk("credit_r0_blocked", bus.oReqRdy[0], 1'b0);
            step();
        end
        for (int n = 0; n < 2; n++) begin
            bus.iReqVld = 2'b11;
            mid();
            chk("credit_r1_flows", bus.oReqRdy, 2'b10);
            step();
            bus.iReqVld = 2'b01;
            repeat (5) step();
        end

        // Pop frees credit only from the following cycle
        bus.iRspRdy = 2'b11;
        mid();
        chk("pop_rspvld", bus.oRspVld[0], 1'b1);
        chk("pop_same_cycle_rdy", bus.oReqRdy[0], 1'b0);
        step();
        mid();
        chk("pop_next_cycle_rdy", bus.oReqRdy[0], 1'b1);
        step();
        bus.iReqVld = 2'b00;
        repeat (10) step();

        // Reset with an operation in flight
        bus.iReqVld = 2'b10;
        mid();
        chk("rst_issue_r1", bus.oReqRdy, 2'b10);
        step();
        bus.iReqVld = 2'b00;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            mid();
            chk("post_rst_rspvld", bus.oRspVld, 2'b00);
            chk("post_rst_busy", bus.oBusy, 1'b0);
            step();
        end
        bus.iReqVld = 2'b11;
        mid();
        chk("post_rst_first_grant", bus.oReqRdy, 2'b01);
        step();

        // Randomized traffic with occasional resets
        for (int k = 0; k < 3000; k++) begin
            rst = ($urandom % 250 == 0);
            bus.iReqVld = 2'($urandom);
            bus.iRspRdy = {($urandom % 4) != 0, ($urandom % 4) != 0};
            for (int r = 0; r < 2; r++) begin
                set_req(r, rnd_op(), rnd_op(), 1'($urandom), 1'($urandom), 1'($urandom));
            end
            step();
        end
        rst = 1'b0;
        bus.iReqVld = 2'b00;
        bus.iRspRdy = 2'b11;
        repeat (20) step();
        mid();
        chk("final_idle", bus.oBusy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and result width (CpuType width).
REQ-002 SHALL have parameter LAT, default 3: fixed multiplier latency in cycles, legal range 1..4.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port iReqVld  input  2  request valid, one bit per requester r in {0,1}.
REQ-006 SHALL have port oReqRdy  output  2  request accepted this cycle when iReqVld[r] and oReqRdy[r] are both 1.
REQ-007 SHALL have ports iReqS1 and iReqS2  input  2xWIDTH  per-requester operand magnitude source values.
REQ-008 SHALL have ports iReqS1Sign and iReqS2Sign  input  2  per-requester operand signed flags.
REQ-009 SHALL have port iReqHigh  input  2  1 = return high half of product, 0 = low half.
REQ-010 SHALL have ports oMulS1 and oMulS2  output  WIDTH  operands to the shared multiplier.
REQ-011 SHALL have ports oMulS1Sign and oMulS2Sign  output  1  sign flags to the multiplier.
REQ-012 SHALL have port oMulOpEn  output  2  half select: 2'b01 = high, 2'b10 = low, 2'b00 = idle.
REQ-013 SHALL have port oMulVld  output  1  operation issued to the multiplier this cycle.
REQ-014 SHALL have port iMulResult  input  WIDTH  multiplier result, valid exactly LAT cycles after its oMulVld cycle.
REQ-015 SHALL have port oRspVld  output  2  per-requester result available.
REQ-016 SHALL have port iRspRdy  input  2  per-requester consumer ready; pop on oRspVld[r] and iRspRdy[r].
REQ-017 SHALL have port oRspData  output  2xWIDTH  per-requester result at buffer head.
REQ-018 SHALL have port oBusy  output  1  any operation in flight or any buffered result.

Function
REQ-019 SHALL issue at most one operation per cycle; oMulVld = accept of any requester, combinational in the accept cycle.
REQ-020 SHALL drive the oMul* operands from the accepted requester in the accept cycle; when oMulVld = 0, operands and signs SHALL be 0 and oMulOpEn = 2'b00.
REQ-021 SHALL arbitrate round-robin: a registered pointer names the priority requester; after a grant to r, the pointer SHALL move to 1-r; without a grant it holds.
REQ-022 SHALL grant the non-priority requester when the priority requester is not requesting or is out of credit.
REQ-023 SHALL keep a per-requester registered credit count cnt[r] (in-flight ops plus buffered results), range 0..2.
REQ-024 SHALL make oReqRdy[r] a function of registered state and iReqVld only: cnt[r] < 2 and the arbiter grants r; there is no combinational path from iRspRdy.
REQ-025 SHALL update cnt[r]: +1 on accept, -1 on pop, unchanged when both occur in the same cycle.
REQ-026 SHALL track in-flight ops in a LAT-deep tag shift register of {valid, id}, advancing every cycle with no stall.
REQ-027 SHALL write iMulResult into the 2-entry FIFO of the tagged id at the end of cycle T+LAT, where T is the issue cycle; oRspVld[r] rises in cycle T+LAT+1.
REQ-028 SHALL drive oRspVld[r] = FIFO[r] not empty and oRspData[r] = FIFO[r] head; oRspData = 0 when the FIFO is empty.
REQ-029 SHALL allow a FIFO write and a pop in the same cycle, including when the FIFO holds 2 entries; the credit rule guarantees no overflow.
REQ-030 SHALL preserve per-requester result order equal to acceptance order.
REQ-031 SHALL drive oBusy = any tag valid or any FIFO non-empty.

Reset
REQ-032 SHALL, while rst = 1, clear all tag valids, FIFOs and cnt to 0 and set the pointer to requester 0.
REQ-033 SHALL hold oReqRdy, oMulVld, oRspVld and oBusy at 0 while rst = 1.
REQ-034 SHALL discard iMulResult values belonging to operations issued before reset.

Verification
REQ-035 SHALL pass this test (WIDTH=32, LAT=3): r0 requests S1=7, S2=6, unsigned, low half in cycle 0; multiplier model returns 42 in cycle 3 -> oMulVld=1 and oMulOpEn=2'b10 in cycle 0, oRspVld[0]=1 with oRspData[0]=42 in cycle 4.
REQ-036 SHALL pass this test: both requesters hold iReqVld=1 with iRspRdy=2'b11 -> grants in cycles 0..3 are r0, r1, r0, r1.
REQ-037 SHALL pass this test: iRspRdy[0]=0 while r0 offers 3 ops -> 2 are accepted, oReqRdy[0]=0 from then on, and r1 continues to be accepted each cycle it requests.
REQ-038 SHALL pass this test: with cnt[0]=2, pop r0 in cycle N -> oReqRdy[0]=0 in cycle N and 1 in cycle N+1.
REQ-039 SHALL pass this test: r1 issues in cycle 0 and rst=1 in cycle 1 -> oRspVld stays 0 permanently, oBusy=0 from cycle 2, and the first grant after reset goes to r0 when both request.
REQ-040 SHALL pass this test: r0 requests high half of 0xFFFFFFFF x 0xFFFFFFFF, unsigned -> oMulOpEn=2'b01 and oRspData[0] equals the model high word 0xFFFFFFFE.
